// File: rtl/onewire_transceiver.sv
// 1-Wire bus master byte engine: bus reset/presence, write byte and read byte, LSB first.
// Open-drain style: the engine only ever enables a pull-down, the pad does the rest.
`timescale 1ns/1ps
module onewire_transceiver #(
    parameter int unsigned T_RSTL   = 48000,
    parameter int unsigned T_PDS    = 7000,
    parameter int unsigned T_RSTH   = 48000,
    parameter int unsigned T_LOW1   = 600,
    parameter int unsigned T_LOW0   = 6000,
    parameter int unsigned T_SAMPLE = 1500,
    parameter int unsigned T_SLOT   = 7000,
    parameter int unsigned T_REC    = 200,
    parameter int unsigned CNT_W    = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       presence,
    output logic       busy,
    output logic       done,
    output logic       bus_drive_low,
    input  logic       bus_in
);
    typedef enum logic [2:0] {
        StIdle, StRstLow, StRstHigh, StSlotLow, StSlotHigh, StFinish
    } state_e;

    localparam logic [1:0] CmdReset = 2'b01;
    localparam logic [1:0] CmdWrite = 2'b10;
    localparam logic [1:0] CmdRead  = 2'b11;

    localparam logic [CNT_W-1:0] RstlEnd   = CNT_W'(T_RSTL - 1);
    localparam logic [CNT_W-1:0] PdsPoint  = CNT_W'(T_PDS);
    localparam logic [CNT_W-1:0] RsthEnd   = CNT_W'(T_RSTH - 1);
    localparam logic [CNT_W-1:0] Low1End   = CNT_W'(T_LOW1 - 1);
    localparam logic [CNT_W-1:0] Low0End   = CNT_W'(T_LOW0 - 1);
    localparam logic [CNT_W-1:0] SamplePt  = CNT_W'(T_SAMPLE);
    localparam logic [CNT_W-1:0] SlotEnd   = CNT_W'(T_SLOT + T_REC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [7:0]       rx_q, rx_d;
    logic             pres_q, pres_d;
    logic             pres_tmp_q, pres_tmp_d;
    logic             drive_low_q, drive_low_d;
    logic [1:0]       sync_q;
    logic             bus_s;
    logic [CNT_W-1:0] low_end;

    assign bus_s         = sync_q[1];
    assign rx_byte       = rx_q;
    assign presence      = pres_q;
    assign bus_drive_low = drive_low_q;
    // Only a write of a 0 bit stretches the low phase; read slots use the short pulse.
    assign low_end       = (cmd_q == CmdWrite && !shreg_q[0]) ? Low0End : Low1End;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        cmd_d      = cmd_q;
        rx_d       = rx_q;
        pres_d     = pres_q;
        pres_tmp_d = pres_tmp_q;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy    = 1'b0;
                timer_d = '0;
                if (start && cmd != 2'b00) begin
                    cmd_d     = cmd;
                    shreg_d   = tx_byte;
                    bit_cnt_d = 3'd0;
                    state_d   = (cmd == CmdReset) ? StRstLow : StSlotLow;
                end
            end
            StRstLow: begin
                if (timer_q == RstlEnd) begin
                    state_d = StRstHigh;
                    timer_d = '0;
                end
            end
            StRstHigh: begin
                if (timer_q == PdsPoint) pres_tmp_d = ~bus_s;
                if (timer_q == RsthEnd) begin
                    pres_d  = pres_tmp_q;
                    state_d = StFinish;
                    timer_d = '0;
                end
            end
            StSlotLow: begin
                // Timer keeps running into the high phase: slot timing is from slot start.
                if (timer_q == low_end) state_d = StSlotHigh;
            end
            StSlotHigh: begin
                if (cmd_q == CmdRead && timer_q == SamplePt) shreg_d = {bus_s, shreg_q[7:1]};
                if (timer_q == SlotEnd) begin
                    timer_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        if (cmd_q == CmdRead) rx_d = shreg_q;
                        state_d = StFinish;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (cmd_q == CmdWrite) shreg_d = {1'b0, shreg_q[7:1]};
                        state_d = StSlotLow;
                    end
                end
            end
            StFinish: begin
                done    = 1'b1;
                timer_d = '0;
                state_d = StIdle;
            end
            default: begin
                timer_d = '0;
                state_d = StIdle;
            end
        endcase
        drive_low_d = (state_d == StRstLow) || (state_d == StSlotLow);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            cmd_q       <= 2'b00;
            rx_q        <= 8'h00;
            pres_q      <= 1'b0;
            pres_tmp_q  <= 1'b0;
            drive_low_q <= 1'b0;
            sync_q      <= 2'b11;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            cmd_q       <= cmd_d;
            rx_q        <= rx_d;
            pres_q      <= pres_d;
            pres_tmp_q  <= pres_tmp_d;
            drive_low_q <= drive_low_d;
            sync_q      <= {sync_q[0], bus_in};
        end
    end

endmodule

// File: tb/tb_onewire_transceiver.sv
// Self-checking bench for onewire_transceiver: scripted slave, schedule-level reference model.
`timescale 1ns/1ps
module tb_onewire_transceiver;
    localparam int T_RSTL   = 48;
    localparam int T_PDS    = 7;
    localparam int T_RSTH   = 48;
    localparam int T_LOW1   = 6;
    localparam int T_LOW0   = 60;
    localparam int T_SAMPLE = 15;
    localparam int T_SLOT   = 70;
    localparam int T_REC    = 2;
    localparam int SLOT_LEN = T_SLOT + T_REC;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] rx_byte;
    logic       presence;
    logic       busy;
    logic       done;
    logic       bus_drive_low;
    logic       bus_in;
    logic       slave_pull = 1'b0;

    // Wired-AND bus: low if master or slave pulls.
    assign bus_in = !(bus_drive_low || slave_pull);

    always #5 clock = ~clock;

    onewire_transceiver #(
        .T_RSTL(T_RSTL), .T_PDS(T_PDS), .T_RSTH(T_RSTH), .T_LOW1(T_LOW1), .T_LOW0(T_LOW0),
        .T_SAMPLE(T_SAMPLE), .T_SLOT(T_SLOT), .T_REC(T_REC), .CNT_W(17)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cmd(cmd), .tx_byte(tx_byte),
        .rx_byte(rx_byte), .presence(presence), .busy(busy), .done(done),
        .bus_drive_low(bus_drive_low), .bus_in(bus_in)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_rx = 8'h00;
    logic       exp_pres = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one command and checks timing/results against the model.
    // pa/pb: slave presence window relative to reset release (pa<0: no slave).
    // hold: read slots pull low for slot cycles 0..hold when the slave bit is 0.
    task automatic run_cmd(input string tag, input logic [1:0] c, input logic [7:0] tx,
                           input logic [7:0] sbits, input int hold, input int pa, input int pb,
                           input int inject_k);
        int p_start[$];
        int p_width[$];
        int e_start[$];
        int e_width[$];
        int done_k, limit, n_done, done_at, busy_cycles, rx_changes, cur_start, rel, j, t;
        logic prev_low;
        logic [7:0] rx0, rx_at_done;
        logic pres_at_done;
        n_done = 0; done_at = -1; busy_cycles = 0; rx_changes = 0; cur_start = 0;
        rx_at_done = 8'hxx; pres_at_done = 1'bx;
        rx0 = rx_byte;
        if (c == 2'b01) begin
            done_k = 1 + T_RSTL + T_RSTH;
            e_start.push_back(1);
            e_width.push_back(T_RSTL);
            // bus_s at the sample point reflects the bus two cycles earlier
            exp_pres = (pa >= 0) && (pa <= T_PDS - 2) && (T_PDS - 2 <= pb);
        end else begin
            done_k = 8 * SLOT_LEN + 1;
            for (int i = 0; i < 8; i++) begin
                e_start.push_back(1 + i * SLOT_LEN);
                e_width.push_back((c == 2'b10 && !tx[i]) ? T_LOW0 : T_LOW1);
            end
            if (c == 2'b11)
                for (int i = 0; i < 8; i++) exp_rx[i] = sbits[i] | (hold < T_SAMPLE - 2);
        end
        limit = done_k + 4;
        start = 1'b1; cmd = c; tx_byte = tx;
        prev_low = bus_drive_low;
        for (int k = 1; k <= limit; k++) begin
            tick();
            start = 1'b0; cmd = 2'b00;
            if (k == inject_k) begin
                start = 1'b1; cmd = 2'b11; tx_byte = 8'h00;
            end
            slave_pull = 1'b0;
            if (c == 2'b01 && pa >= 0) begin
                rel = k - 1 - T_RSTL;
                slave_pull = (rel >= pa) && (rel <= pb);
            end
            if (c == 2'b11) begin
                j = (k - 1) / SLOT_LEN;
                t = (k - 1) % SLOT_LEN;
                slave_pull = (j < 8) && !sbits[j] && (t <= hold);
            end
            if (bus_drive_low && !prev_low) cur_start = k;
            if (!bus_drive_low && prev_low) begin
                p_start.push_back(cur_start);
                p_width.push_back(k - cur_start);
            end
            prev_low = bus_drive_low;
            if (done === 1'b1) begin
                n_done++; done_at = k; rx_at_done = rx_byte; pres_at_done = presence;
            end
            if (busy === 1'b1) busy_cycles++;
            if (k < done_k && rx_byte !== rx0) rx_changes++;
        end
        slave_pull = 1'b0;
        check({tag, ".done_count"}, n_done, 1);
        check({tag, ".done_cycle"}, done_at, done_k);
        check({tag, ".busy_cycles"}, busy_cycles, done_k);
        check({tag, ".pulse_count"}, p_start.size(), e_start.size());
        for (int i = 0; i < e_start.size() && i < p_start.size(); i++) begin
            check($sformatf("%s.pulse%0d_start", tag, i), p_start[i], e_start[i]);
            check($sformatf("%s.pulse%0d_width", tag, i), p_width[i], e_width[i]);
        end
        check({tag, ".rx_held"}, rx_changes, 0);
        check({tag, ".rx_byte"}, rx_at_done, exp_rx);
        check({tag, ".presence"}, pres_at_done, exp_pres);
        check({tag, ".idle_after"}, busy, 0);
    endtask

    initial begin
        int idle_busy, idle_done, idle_low, a, b, n_done;
        logic [7:0] r;

        repeat (3) tick();
        check("rst.rx_byte", rx_byte, 8'h00);
        check("rst.presence", presence, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.drive_low", bus_drive_low, 0);
        reset = 1'b1;
        repeat (3) tick();

        run_cmd("reset_slave", 2'b01, 8'h00, 8'h00, 0, 2, 30, 0);
        run_cmd("reset_noslave", 2'b01, 8'h00, 8'h00, 0, -1, -1, 0);
        run_cmd("reset_slave2", 2'b01, 8'h00, 8'h00, 0, 2, 30, 0);
        run_cmd("write_a5", 2'b10, 8'hA5, 8'h00, 0, -1, -1, 0);
        run_cmd("read_3c", 2'b11, 8'h00, 8'h3C, 30, -1, -1, 0);
        run_cmd("write_inject", 2'b10, 8'h69, 8'h00, 0, -1, -1, 100);

        // start with cmd=00 in idle must be ignored
        start = 1'b1; cmd = 2'b00; tx_byte = 8'hFF;
        idle_busy = 0; idle_done = 0; idle_low = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            start = 1'b0;
            if (busy) idle_busy++;
            if (done) idle_done++;
            if (bus_drive_low) idle_low++;
        end
        check("nop.busy", idle_busy, 0);
        check("nop.done", idle_done, 0);
        check("nop.drive_low", idle_low, 0);

        for (int n = 0; n < 3; n++) begin
            r = 8'($urandom);
            run_cmd($sformatf("rand_read%0d", n), 2'b11, 8'h00, r, int'($urandom_range(50, 5)),
                    -1, -1, 0);
        end
        for (int n = 0; n < 2; n++) begin
            r = 8'($urandom);
            run_cmd($sformatf("rand_write%0d", n), 2'b10, r, 8'h00, 0, -1, -1, 0);
        end
        for (int n = 0; n < 2; n++) begin
            a = int'($urandom_range(10, 0));
            b = a + int'($urandom_range(30, 0));
            run_cmd($sformatf("rand_reset%0d", n), 2'b01, 8'h00, 8'h00, 0, a, b, 0);
        end

        // Async reset during slot 3 of a write, while the bus is held low
        start = 1'b1; cmd = 2'b10; tx_byte = 8'h5A;
        for (int k = 1; k <= 1 + 3 * SLOT_LEN + 3; k++) begin
            tick();
            start = 1'b0; cmd = 2'b00;
        end
        check("abort.low_before", bus_drive_low, 1);
        #2 reset = 1'b0;
        #1;
        check("abort.drive_low", bus_drive_low, 0);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        exp_rx = 8'h00; exp_pres = 1'b0;
        n_done = 0;
        repeat (3) begin
            tick();
            if (done) n_done++;
        end
        check("abort.rx_cleared", rx_byte, exp_rx);
        check("abort.pres_cleared", presence, exp_pres);
        reset = 1'b1;
        repeat (20) begin
            tick();
            if (done) n_done++;
        end
        check("abort.no_done", n_done, 0);
        run_cmd("write_ff", 2'b10, 8'hFF, 8'h00, 0, -1, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
